apb_master_bridge: RTL

APB4 requester that turns single-beat valid/ready memory requests from the core's LSU/IFU arbiter into APB transactions toward APB peripherals (SDRAM bridge, UART, SPI, …). It sits between the core-side crossbar and the peripheral APB bus. It carries one outstanding transaction at a time. Each accepted request produces exactly one response, read data or error, on a valid/ready response channel.

---
 rtl/apb_master_bridge.sv | 110 +++++++++++
 1 files changed

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-outstanding valid/ready request -> APB4 requester.
// Optional ACCESS-phase timeout is compiled in when APB_MASTER_TIMEOUT_EN is defined.
module apb_master_bridge #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
    input  logic [2:0]          req_prot,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic [ADDR_W-1:0]   out_paddr,
    output logic                out_psel,
    output logic                out_penable,
    output logic [2:0]          out_pprot,
    output logic                out_pwrite,
    output logic [DATA_W-1:0]   out_pwdata,
    output logic [DATA_W/8-1:0] out_pstrb,
    input  logic                out_pready,
    input  logic [DATA_W-1:0]   out_prdata,
    input  logic                out_pslverr
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
    state_t state;
    logic   timed_out;

    assign req_ready  = (state == IDLE) && !reset;
    assign resp_valid = (state == RESP);

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;

    // This not-ready ACCESS cycle is the one that brings the count to the limit.
    assign timed_out = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset || state == SETUP)
            wait_cnt <= '0;
        else if (state == ACCESS && !out_pready)
            wait_cnt <= wait_cnt + 1'b1;
    end
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            out_psel    <= 1'b0;
            out_penable <= 1'b0;
            out_paddr   <= '0;
            out_pwrite  <= 1'b0;
            out_pwdata  <= '0;
            out_pstrb   <= '0;
            out_pprot   <= '0;
            resp_rdata  <= '0;
            resp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        out_paddr   <= req_addr;
                        out_pwrite  <= req_write;
                        out_pwdata  <= req_wdata;
                        out_pstrb   <= req_write ? req_wstrb : '0;
                        out_pprot   <= req_prot;
                        out_psel    <= 1'b1;
                        out_penable <= 1'b0;
                        state       <= SETUP;
                    end
                end
                SETUP: begin
                    out_penable <= 1'b1;
                    state       <= ACCESS;
                end
                ACCESS: begin
                    if (out_pready) begin
                        // Writes and errored transfers never return data.
                        resp_rdata  <= (out_pwrite || out_pslverr) ? '0 : out_prdata;
                        resp_err    <= out_pslverr;
                        out_psel    <= 1'b0;
                        out_penable <= 1'b0;
                        state       <= RESP;
                    end else if (timed_out) begin
                        resp_rdata  <= '0;
                        resp_err    <= 1'b1;
                        out_psel    <= 1'b0;
                        out_penable <= 1'b0;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
